// File: rtl/rice_core_fetch_pc_gen.sv
// Next-PC generator at the head of fetch: drives the predictor lookup PC and issues
// fetch requests carrying the prediction used, frozen while a request is stalled.
module rice_core_fetch_pc_gen #(
  parameter int unsigned    XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_enable,
  input  logic            i_flush,
  input  logic [XLEN-1:0] i_flush_pc,
  output logic [XLEN-1:0] o_pc,
  input  logic            i_bp_taken,
  input  logic [XLEN-1:0] i_bp_target_pc,
  output logic            o_req_valid,
  input  logic            i_req_ready,
  output logic [XLEN-1:0] o_req_pc,
  output logic            o_req_pred_taken,
  output logic [XLEN-1:0] o_req_pred_target_pc
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_FETCH    = 2'd1;
  localparam logic [1:0] ST_REDIRECT = 2'd2;

  localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);
  localparam logic [XLEN-1:0] PC_ALIGN = ~XLEN'(3);

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            hold_q, hold_d;
  logic            held_taken_q, held_taken_d;
  logic [XLEN-1:0] held_target_q, held_target_d;

  logic [XLEN-1:0] pc_plus4;
  logic            live_taken;
  logic [XLEN-1:0] live_target;
  logic            in_fetch;
  logic            req_valid;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic            fire;
  logic            stall;

  // Request datapath: live prediction unless a stalled request froze it.
  always_comb begin
    pc_plus4    = pc_q + PC_STEP;
    live_taken  = i_enable & i_bp_taken;
    live_target = live_taken ? i_bp_target_pc : pc_plus4;
    in_fetch    = (state_q == ST_FETCH);
    req_valid   = in_fetch & ~i_flush;
    pred_taken  = 1'b0;
    pred_target = '0;
    if (in_fetch) begin
      if (hold_q) begin
        pred_taken  = held_taken_q;
        pred_target = held_target_q;
      end else begin
        pred_taken  = live_taken;
        pred_target = live_target;
      end
    end
    fire  = req_valid & i_req_ready;
    stall = req_valid & ~i_req_ready;
  end

  // Next-state logic; flush outranks every handshake outcome.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    hold_d        = hold_q;
    held_taken_d  = held_taken_q;
    held_target_d = held_target_q;
    if (i_flush) begin
      state_d = ST_REDIRECT;
      pc_d    = i_flush_pc & PC_ALIGN;
      hold_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE:     state_d = ST_FETCH;
        ST_REDIRECT: state_d = ST_FETCH;
        ST_FETCH: begin
          if (fire) begin
            pc_d   = pred_taken ? (pred_target & PC_ALIGN) : pc_plus4;
            hold_d = 1'b0;
          end else if (stall) begin
            hold_d        = 1'b1;
            held_taken_d  = pred_taken;
            held_target_d = pred_target;
          end
        end
        default:     state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      hold_q        <= 1'b0;
      held_taken_q  <= 1'b0;
      held_target_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      hold_q        <= hold_d;
      held_taken_q  <= held_taken_d;
      held_target_q <= held_target_d;
    end
  end

  assign o_pc                 = pc_q;
  assign o_req_pc             = pc_q;
  assign o_req_valid          = req_valid;
  assign o_req_pred_taken     = pred_taken;
  assign o_req_pred_target_pc = pred_target;

endmodule

// File: tb/tb_rice_core_fetch_pc_gen.sv
// Directed bench for the fetch next-PC generator; inputs change at the falling edge
// and outputs are compared 1ns later, well before the next rising edge.
module tb_rice_core_fetch_pc_gen;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_enable;
  logic        i_flush;
  logic [31:0] i_flush_pc;
  logic [31:0] o_pc;
  logic        i_bp_taken;
  logic [31:0] i_bp_target_pc;
  logic        o_req_valid;
  logic        i_req_ready;
  logic [31:0] o_req_pc;
  logic        o_req_pred_taken;
  logic [31:0] o_req_pred_target_pc;

  int checks   = 0;
  int failures = 0;

  rice_core_fetch_pc_gen #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .i_clk                (i_clk),
    .i_rst                (i_rst),
    .i_enable             (i_enable),
    .i_flush              (i_flush),
    .i_flush_pc           (i_flush_pc),
    .o_pc                 (o_pc),
    .i_bp_taken           (i_bp_taken),
    .i_bp_target_pc       (i_bp_target_pc),
    .o_req_valid          (o_req_valid),
    .i_req_ready          (i_req_ready),
    .o_req_pc             (o_req_pc),
    .o_req_pred_taken     (o_req_pred_taken),
    .o_req_pred_target_pc (o_req_pred_target_pc)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to the next cycle and apply this cycle's inputs.
  task automatic next_cycle(input logic rst, input logic en, input logic flush,
                            input logic [31:0] flush_pc, input logic bp_taken,
                            input logic [31:0] bp_target, input logic ready);
    @(negedge i_clk);
    i_rst          = rst;
    i_enable       = en;
    i_flush        = flush;
    i_flush_pc     = flush_pc;
    i_bp_taken     = bp_taken;
    i_bp_target_pc = bp_target;
    i_req_ready    = ready;
    #1;
  endtask

  task automatic check_req(input string tag, input logic valid, input logic [31:0] pc,
                           input logic taken, input logic [31:0] target);
    check({tag, ".valid"}, 32'(o_req_valid), 32'(valid));
    check({tag, ".pc"}, o_req_pc, pc);
    check({tag, ".o_pc"}, o_pc, pc);
    if (valid) begin
      check({tag, ".taken"}, 32'(o_req_pred_taken), 32'(taken));
      check({tag, ".target"}, o_req_pred_target_pc, target);
    end
  endtask

  initial begin
    i_rst = 1'b1; i_enable = 1'b1; i_flush = 1'b0; i_flush_pc = '0;
    i_bp_taken = 1'b0; i_bp_target_pc = '0; i_req_ready = 1'b1;
    repeat (2) @(posedge i_clk);

    // Reset state, first cycle out of reset is the IDLE bubble
    next_cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    check("rst.valid", 32'(o_req_valid), 32'h0);
    check("rst.pc", o_req_pc, 32'h0);
    check("rst.taken", 32'(o_req_pred_taken), 32'h0);
    check("rst.target", o_req_pred_target_pc, 32'h0);
    next_cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    check("idle.valid", 32'(o_req_valid), 32'h0);

    // Sequential fetch
    next_cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    check_req("seq0", 1'b1, 32'h0, 1'b0, 32'h4);
    next_cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    check_req("seq4", 1'b1, 32'h4, 1'b0, 32'h8);

    // Prediction disabled overrides a taken predictor result
    next_cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h400, 1'b1);
    check_req("dis8", 1'b1, 32'h8, 1'b0, 32'hC);
    next_cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    check_req("seqC", 1'b1, 32'hC, 1'b0, 32'h10);

    // Back-to-back taken predictions, no bubble
    next_cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h80, 1'b1);
    check_req("tk10", 1'b1, 32'h10, 1'b1, 32'h80);
    next_cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h20, 1'b1);
    check_req("tk80", 1'b1, 32'h80, 1'b1, 32'h20);

    // Stall at 0x20: prediction frozen while the predictor flips to taken
    next_cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    check_req("stall1", 1'b1, 32'h20, 1'b0, 32'h24);
    next_cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h300, 1'b0);
    check_req("stall2", 1'b1, 32'h20, 1'b0, 32'h24);
    next_cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h300, 1'b0);
    check_req("stall3", 1'b1, 32'h20, 1'b0, 32'h24);
    next_cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h300, 1'b1);
    check_req("stall_hs", 1'b1, 32'h20, 1'b0, 32'h24);

    // Flush with an unaligned target while the request would handshake
    next_cycle(1'b0, 1'b1, 1'b1, 32'h203, 1'b0, 32'h0, 1'b1);
    check_req("flush", 1'b0, 32'h24, 1'b0, 32'h0);
    next_cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    check_req("redir", 1'b0, 32'h200, 1'b0, 32'h0);
    next_cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFE, 1'b1);
    check_req("post_flush", 1'b1, 32'h200, 1'b1, 32'hFFFF_FFFE);

    // Wrap of pc+4 at the top of the address space
    next_cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    check_req("top", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    next_cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    check_req("wrap", 1'b1, 32'h0, 1'b0, 32'h4);

    // Reset together with flush: reset wins
    next_cycle(1'b1, 1'b1, 1'b1, 32'h500, 1'b0, 32'h0, 1'b1);
    next_cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    check_req("rstflush", 1'b0, 32'h0, 1'b0, 32'h0);
    check("rstflush.target", o_req_pred_target_pc, 32'h0);
    next_cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    check_req("rstflush_fetch", 1'b1, 32'h0, 1'b0, 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
